// File: rtl/my_adder_arbiter.sv
// my_adder_arbiter: shares one combinational my_adder between two requesters.
// Operand pairs arrive over valid/ready handshakes and are latched. One addition
// runs at a time. The registered sum goes back on a shared bus, with a separate
// response valid/ready pair for each requester.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req{0,1}_valid/_ready      operand handshake (ready is combinational, IDLE only)
//   req{0,1}_a, req{0,1}_b     operands, WIDTH bits
//   rsp{0,1}_valid/_ready      result handshake for the owning requester
//   rsp_data                   registered sum, held after a transfer completes
//   rsp_carry                  registered carry-out (only with MY_ADDER_ARBITER_CARRY_EN)
//   busy                       high whenever the FSM is not in IDLE
//
// Build option: MY_ADDER_ARBITER_CARRY_EN adds the rsp_carry port.
// Only WIDTH = 16 is supported, which matches the shared adder.

module my_adder #(
  parameter int WIDTH = 16,
  parameter int OUT_W = WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [OUT_W-1:0] sum_o
);
  assign sum_o = OUT_W'(a_i) + OUT_W'(b_i);
endmodule

// state | meaning
// IDLE  | waiting for a request; ready goes to the granted requester
// CALC  | adder is fed from the operand registers; the sum is captured at the next edge
// RESP  | rsp<owner>_valid is high; waits for rsp<owner>_ready
module my_adder_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef MY_ADDER_ARBITER_CARRY_EN
  output logic             rsp_carry,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

`ifdef MY_ADDER_ARBITER_CARRY_EN
  localparam int SUM_W = WIDTH + 1;
`else
  localparam int SUM_W = WIDTH;
`endif

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SUM_W-1:0] sum;
  logic             grant0, grant1;
`ifdef MY_ADDER_ARBITER_CARRY_EN
  logic             carry_q, carry_d;
`endif

  my_adder #(.WIDTH(WIDTH), .OUT_W(SUM_W)) u_adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (sum)
  );

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
`ifdef MY_ADDER_ARBITER_CARRY_EN
    carry_d    = carry_q;
`endif
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Requester 1 wins if it is alone, or on a tie when it holds priority.
        grant1 = req1_valid && (!req0_valid || prio_q);
        grant0 = req0_valid && !grant1;
        // Keep ready low while reset is held so nothing looks accepted.
        req0_ready = grant0 && rst_n;
        req1_ready = grant1 && rst_n;
        if (grant0 || grant1) begin
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          owner_d = grant1;
          prio_d  = !grant1;
          state_d = CALC;
        end
      end
      CALC: begin
        data_d  = sum[WIDTH-1:0];
`ifdef MY_ADDER_ARBITER_CARRY_EN
        carry_d = sum[WIDTH];
`endif
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
`ifdef MY_ADDER_ARBITER_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
`ifdef MY_ADDER_ARBITER_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign rsp_data = data_q;
`ifdef MY_ADDER_ARBITER_CARRY_EN
  assign rsp_carry = carry_q;
`endif
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_my_adder_arbiter.sv
// Scoreboard testbench for my_adder_arbiter. Each requester's expected sums are
// queued when that requester presents an operand pair. A negedge monitor pops
// and compares them on every response handshake. The same monitor checks
// round-robin grants, latency and hold-under-backpressure against a reference
// arbiter model kept in the bench.
module tb_my_adder_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        busy;
`ifdef MY_ADDER_ARBITER_CARRY_EN
  logic        rsp_carry;
`endif

  my_adder_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
`ifdef MY_ADDER_ARBITER_CARRY_EN
    .rsp_carry(rsp_carry),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] pend0[$], pend1[$];
  logic [16:0] exp0[$], exp1[$];
  logic        grant_log[$];

  logic rr_rand = 1'b0;
  logic gaps = 1'b0;

  logic s_acc0, s_acc1, s_rsp0_valid, s_rsp1_valid, s_req1_ready;
  logic [15:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model state: round-robin pointer plus bookkeeping for the checks.
  logic        prio_m = 1'b0;
  logic        last_g = 1'b0;
  logic        pv0 = 1'b0, pv1 = 1'b0, pr0 = 1'b0, pr1 = 1'b0;
  logic [15:0] pdata = '0;
  int          cyc = 0;
  int          acc_cyc = -100;

  always @(negedge clk) begin
    logic [16:0] e;
    logic        g, eg;
    if (!rst_n) begin
      prio_m = 1'b0;
      pv0 = 1'b0; pv1 = 1'b0;
      acc_cyc = -100;
    end else begin
      cyc++;
      if (rsp0_valid && rsp1_valid) fail_now("rsp_both_valid");
      if (pv0 && !pr0) begin
        chk("hold_valid0", rsp0_valid, 1);
        chk("hold_data0", rsp_data, pdata);
      end
      if (pv1 && !pr1) begin
        chk("hold_valid1", rsp1_valid, 1);
        chk("hold_data1", rsp_data, pdata);
      end
      if ((rsp0_valid || rsp1_valid) && !pv0 && !pv1) begin
        chk("latency", cyc - acc_cyc, 2);
        chk("rsp_owner", rsp1_valid, last_g);
        chk("busy_in_resp", busy, 1);
      end
      if (rsp0_valid && rsp0_ready) begin
        if (exp0.size() == 0) fail_now("rsp0_spurious");
        else begin
          e = exp0.pop_front();
          chk("rsp0_data", rsp_data, e[15:0]);
`ifdef MY_ADDER_ARBITER_CARRY_EN
          chk("rsp0_carry", rsp_carry, e[16]);
`endif
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp1.size() == 0) fail_now("rsp1_spurious");
        else begin
          e = exp1.pop_front();
          chk("rsp1_data", rsp_data, e[15:0]);
`ifdef MY_ADDER_ARBITER_CARRY_EN
          chk("rsp1_carry", rsp_carry, e[16]);
`endif
        end
      end
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        chk("ready_onehot", req0_ready & req1_ready, 0);
        chk("ready_when_idle", busy, 0);
        chk("ready_has_valid", g ? req1_valid : req0_valid, 1);
        eg = (req0_valid && req1_valid) ? prio_m : req1_valid;
        chk("grant_order", g, eg);
        prio_m = !g;
        last_g = g;
        grant_log.push_back(g);
        acc_cyc = cyc;
      end else if (!busy && (req0_valid || req1_valid)) begin
        fail_now("idle_no_grant");
      end
      pv0 = rsp0_valid; pv1 = rsp1_valid;
      pr0 = rsp0_ready; pr1 = rsp1_ready;
      pdata = rsp_data;
    end
  end

  // One clock of stimulus: snapshot at negedge, update inputs just after posedge.
  task automatic step();
    logic [15:0] a, b;
    @(negedge clk);
    s_acc0 = req0_valid && req0_ready;
    s_acc1 = req1_valid && req1_ready;
    s_rsp0_valid = rsp0_valid;
    s_rsp1_valid = rsp1_valid;
    s_req1_ready = req1_ready;
    s_data = rsp_data;
    @(posedge clk);
    #1;
    if (s_acc0) req0_valid = 1'b0;
    if (s_acc1) req1_valid = 1'b0;
    if (!req0_valid && pend0.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      {a, b} = pend0.pop_front();
      req0_a = a; req0_b = b; req0_valid = 1'b1;
      exp0.push_back({1'b0, a} + {1'b0, b});
    end
    if (!req1_valid && pend1.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      {a, b} = pend1.pop_front();
      req1_a = a; req1_b = b; req1_valid = 1'b1;
      exp1.push_back({1'b0, a} + {1'b0, b});
    end
    if (rr_rand) begin
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || req0_valid || req1_valid ||
            exp0.size() > 0 || exp1.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    pend0.delete(); pend1.delete();
    exp0.delete(); exp1.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
`ifdef MY_ADDER_ARBITER_CARRY_EN
    chk("rst_rsp_carry", rsp_carry, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Single request with latency check.
    do_reset();
    pend0.push_back({16'd1024, 16'd1});
    s_acc0 = 1'b0;
    for (int i = 0; i < 10 && !s_acc0; i++) step();
    if (!s_acc0) fail_now("t1_accept_timeout");
    step();
    chk("t1_cyc1_rsp0_valid", s_rsp0_valid, 0);
    step();
    chk("t1_cyc2_rsp0_valid", s_rsp0_valid, 1);
    chk("t1_rsp_data", s_data, 1025);
    chk("t1_rsp1_valid", s_rsp1_valid, 0);
    drain(50);

    // Simultaneous requests after reset, then overflow on requester 1.
    do_reset();
    grant_log.delete();
    pend0.push_back({16'd1024, 16'd1024});
    pend1.push_back({16'd65534, 16'd1});
    drain(50);
    chk("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first", grant_log[0], 0);
      chk("t2_second", grant_log[1], 1);
    end
    pend1.push_back({16'hFFFF, 16'd1});
    drain(50);
    chk("t3_wrap_data", rsp_data, 0);

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    rsp0_ready = 1'b0;
    pend0.push_back({16'd1000, 16'd2000});
    pend1.push_back({16'd3, 16'd4});
    s_rsp0_valid = 1'b0;
    for (int i = 0; i < 10 && !s_rsp0_valid; i++) step();
    if (!s_rsp0_valid) fail_now("t4_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", s_rsp0_valid, 1);
      chk("t4_hold_data", s_data, 3000);
      chk("t4_req1_blocked", s_req1_ready, 0);
    end
    rsp0_ready = 1'b1;
    step();
    step();
    chk("t4_req1_first_idle", s_req1_ready, 1);
    drain(50);

    // Fairness: both requesters continuously valid for four operations.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      pend0.push_back({16'(100 + i), 16'd5});
      pend1.push_back({16'(200 + i), 16'd7});
    end
    drain(100);
    chk("t5_grants", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      chk("t5_order", grant_log[i], i % 2);

    // Randomized traffic with random response backpressure.
    rr_rand = 1'b1;
    gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pend0.push_back({rand_op(), rand_op()});
      pend1.push_back({rand_op(), rand_op()});
    end
    drain(4000);
    rr_rand = 1'b0;
    gaps = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset in the cycle after acceptance aborts the operation.
    pend1.push_back({16'd500, 16'd600});
    drain(50);
    chk("t6_prev_data", rsp_data, 1100);
    pend0.push_back({16'd7, 16'd8});
    s_acc0 = 1'b0;
    for (int i = 0; i < 10 && !s_acc0; i++) step();
    if (!s_acc0) fail_now("t6_accept_timeout");
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_no_rsp0", s_rsp0_valid, 0);
      chk("t6_no_rsp1", s_rsp1_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/my_adder_arbiter.md
# my_adder_arbiter

Two-requester, round-robin arbiter and sequencer that shares one `my_adder` instance (16-bit, combinational, result mod 2^16) between two clients. It accepts operand pairs through valid/ready handshakes, latches them, and launches one addition at a time. It returns each sum on the shared result bus with a per-requester response handshake. It sits between the client blocks and the single adder so neither client drives the adder directly.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width. Must equal the `my_adder` width; only 16 is supported.

Ports:
- One clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  operand pair accepted this cycle when high with `req0_valid`.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp0_valid`  out  1  result for requester 0 is on `rsp_data`.
- `rsp0_ready`  in  1  requester 0 takes the result.
- `rsp1_valid`, `rsp1_ready`: same as requester 0, for requester 1.
- `rsp_data`  out  WIDTH  shared registered sum.
- `rsp_carry`  out  1  carry-out of the sum; present only with `MY_ADDER_ARBITER_CARRY_EN`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- Round-robin pointer `prio` resets to 0.
- **IDLE**
  - If exactly one `reqN_valid` is high, requester N is granted.
  - If both are high, requester `prio` is granted.
  - `reqN_ready` = (state == IDLE) && granted N. Ready is combinational, and at most one ready is high at a time.
  - On acceptance: latch a/b into operand registers, record owner = N, set `prio` = the other requester (1-N), and go to CALC.
- **CALC**
  - The adder is driven from the operand registers.
  - The sum is registered into `rsp_data` (and `rsp_carry`), then go to RESP.
- **RESP**
  - `rsp<owner>_valid` = 1. The other rsp_valid stays 0.
  - `rsp_data` is held stable.
  - When `rsp<owner>_ready` = 1, the transfer completes and the FSM returns to IDLE.
- No new request is accepted outside IDLE. Requests are not dropped; clients hold valid until they see ready.
- Arithmetic: sum = (a + b) mod 2^WIDTH. Overflow wraps silently, e.g. 65535 + 1 gives 0.
- `rsp_data` keeps its last value after a completed transfer.

## Timing
- Reset values: all ready/valid outputs 0, `busy` 0, `rsp_data` 0, `rsp_carry` 0, `prio` 0, state IDLE.
- Acceptance at edge E moves the FSM to CALC. Data is registered at edge E+1, so `rsp_valid` is high in the cycle after E+1.
- Latency is 2 cycles from acceptance to `rsp_valid`.
- Minimum spacing is 3 cycles per operation (IDLE, CALC, RESP with `rsp_ready` already high).
- Backpressure: `rsp_valid` and `rsp_data` are held indefinitely while `rsp_ready` is 0.
- Requests that arrive at the same time are resolved by `prio` only. The pointer advances only on acceptance.
- `rsp_ready` for the non-owner is ignored.
- A reset asserted in any state (including mid-CALC or RESP) aborts the in-flight operation. All outputs take their reset values in the following cycle, and no response is issued.

## Configuration
- `MY_ADDER_ARBITER_CARRY_EN` defined:
  - The adder result is computed at WIDTH+1 bits.
  - The `rsp_carry` port exists and is registered with `rsp_data`. It is 1 when a + b ≥ 2^WIDTH.
- Not defined:
  - The `rsp_carry` port is absent.
  - Carry is discarded and only the wrapped WIDTH-bit sum is returned.

## Test plan
- Single request: req0 1024 + 1 accepted at cycle 0 -> `rsp0_valid` high at cycle 2, `rsp_data` = 1025, `rsp1_valid` = 0.
- Simultaneous requests after reset: req0 (1024, 1024) and req1 (65534, 1) -> req0 served first, `rsp_data` = 2048. Then req1 is served, `rsp_data` = 65535.
- Overflow: req1 65535 + 1 -> `rsp_data` = 0. With `MY_ADDER_ARBITER_CARRY_EN`, `rsp_carry` = 1. For 1024 + 1, `rsp_carry` = 0.
- Backpressure: `rsp0_ready` held 0 for 5 cycles with req1 valid -> `rsp0_valid` and `rsp_data` stable, `req1_ready` stays 0, and req1 is accepted in the first cycle back in IDLE.
- Fairness: both valid continuously for 4 operations -> grant order 0, 1, 0, 1 and `busy` never 0 between operations longer than the IDLE cycle.
- Reset mid-CALC: `rst_n` = 0 in the cycle after acceptance -> next cycle all outputs 0, state IDLE, no `rsp_valid` ever issued for the aborted operation.
